// File: rtl/Types.sv
// Shared datapath types for the ray pipeline.
// Provides the fixed-point word width macros (WIDTH, Q_BITS) and the
// TaggedDirection record: a signed per-axis direction plus an opaque tag.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef Q_BITS
`define Q_BITS 16
`endif

package types_pkg;
  typedef struct packed {
    logic signed [`WIDTH-1:0] x;
    logic signed [`WIDTH-1:0] y;
    logic signed [`WIDTH-1:0] z;
    logic [47:0]              tag;
  } TaggedDirection;
endpackage

// File: rtl/t_calc_arb_pkg.sv
// Types shared by t_calc_arbiter and its users: requester id, default
// response FIFO depth and the packed response FIFO entry.
package t_calc_arb_pkg;
  import types_pkg::*;

  localparam int RSP_DEPTH_DEFAULT = 2;
  localparam int REQ_ID_W          = 3;  // enough for up to 8 requesters

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef struct packed {
    TaggedDirection td;
    req_id_t        id;
  } rsp_entry_t;
endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin picker.
// Ports: req   - request vector
//        en    - allow a grant this cycle
//        ptr   - highest-priority index (searched first, wraps)
//        gnt   - one-hot grant (zero when disabled or idle)
//        idx   - granted index; equals ptr when nothing is granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);
  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = ptr;
    found = 1'b0;
    k     = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IW'((int'(ptr) + i) % NUM_REQ);
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end
endmodule

// File: rtl/t_calc_arbiter.sv
// Round-robin front end sharing one single-cycle t_calc multiplier among
// NUM_REQ requesters, with a credit-guarded response FIFO.
// Ports: clk/rst_n           - clock, async active-low reset
//        req_valid/req_ready - per-requester handshake (ready is one-hot)
//        req_dir/tx/ty/tz    - per-requester operands
//        mul_start/dir/tx..  - issue to t_calc
//        mul_valid/mul_td    - result from t_calc (one cycle after start)
//        rsp_valid/ready/td/id - shared response port (FIFO head)
// Optional: T_CALC_ARB_STATS_EN adds grant_cnt[] and stall_cnt counters.
module t_calc_arbiter
  import types_pkg::*, t_calc_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = `WIDTH,
  parameter int Q_BITS    = `Q_BITS,
  parameter int TAG_SIZE  = 48,
  parameter int RSP_DEPTH = RSP_DEPTH_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  TaggedDirection [NUM_REQ-1:0]         req_dir,
  input  logic signed [NUM_REQ-1:0][WIDTH-1:0] req_tx,
  input  logic signed [NUM_REQ-1:0][WIDTH-1:0] req_ty,
  input  logic signed [NUM_REQ-1:0][WIDTH-1:0] req_tz,
  output logic                                 mul_start,
  output TaggedDirection                       mul_dir,
  output logic signed [WIDTH-1:0]              mul_tx,
  output logic signed [WIDTH-1:0]              mul_ty,
  output logic signed [WIDTH-1:0]              mul_tz,
  input  logic                                 mul_valid,
  input  TaggedDirection                       mul_td,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output TaggedDirection                       rsp_td,
  output logic [$clog2(NUM_REQ)-1:0]           rsp_id
`ifdef T_CALC_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0]             grant_cnt,
  output logic [31:0]                          stall_cnt
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam bit CFG_OK = (WIDTH == `WIDTH) && (TAG_SIZE == 48) &&
                          (Q_BITS >= 0) && (Q_BITS < WIDTH) &&
                          (RSP_DEPTH >= 2) && (NUM_REQ >= 2) && (NUM_REQ <= 8);

  logic [IW-1:0]      rr_ptr, g_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               inflight, arm, eligible, pop, push;
  logic [CW-1:0]      fifo_cnt;
  logic [CW:0]        used;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  req_id_t            id_q;
  rsp_entry_t         mem [RSP_DEPTH];
  rsp_entry_t         head;

  // Credits: FIFO slots already taken plus the result still in t_calc,
  // minus the slot being freed by this cycle's pop.
  assign pop      = rsp_valid && rsp_ready;
  assign used     = {1'b0, fifo_cnt} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign eligible = |req_valid && (used < (CW+1)'(RSP_DEPTH));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .en  (eligible),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (g_idx)
  );

  // Operands follow g_idx, which rests on rr_ptr when idle, so they stay X-free.
  assign req_ready = gnt;
  assign mul_start = |gnt;
  assign mul_dir   = req_dir[g_idx];
  assign mul_tx    = req_tx[g_idx];
  assign mul_ty    = req_ty[g_idx];
  assign mul_tz    = req_tz[g_idx];

  // Only results of an issue made since reset release are captured.
  assign push      = mul_valid && inflight;
  assign head      = mem[rd_ptr];
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_td    = head.td;
  assign rsp_id    = head.id[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      inflight <= 1'b0;
      arm      <= 1'b0;
      id_q     <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
    end else begin
      arm      <= 1'b1;
      inflight <= mul_start;
      if (mul_start) begin
        rr_ptr <= (g_idx == IW'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;
        id_q   <= req_id_t'(g_idx);
      end
      if (push) begin
        mem[wr_ptr] <= '{td: mul_td, id: id_q};
        wr_ptr      <= (wr_ptr == PW'(RSP_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PW'(RSP_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

`ifdef T_CALC_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + 1'b1;
      if (|req_valid && !eligible && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

  a_cfg:      assert property (@(posedge clk) CFG_OK);
  a_no_ovf:   assert property (@(posedge clk) disable iff (!rst_n)
                push |-> (fifo_cnt < CW'(RSP_DEPTH)) || pop);
  a_no_stray: assert property (@(posedge clk) disable iff (!rst_n)
                (mul_valid && arm) |-> inflight);
  a_id_range: assert property (@(posedge clk) disable iff (!rst_n)
                rsp_valid |-> (int'(head.id) < NUM_REQ));
endmodule

// File: tb/tb_t_calc_arbiter.sv
module tb_t_calc_arbiter;
  import types_pkg::*;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]                   req_valid, req_ready;
  TaggedDirection [N-1:0]         req_dir;
  logic signed [N-1:0][31:0]      req_tx, req_ty, req_tz;
  logic                           mul_start;
  TaggedDirection                 mul_dir;
  logic signed [31:0]             mul_tx, mul_ty, mul_tz;
  logic                           mul_valid = 1'b0;
  TaggedDirection                 mul_td = '0;
  logic                           rsp_valid, rsp_ready;
  TaggedDirection                 rsp_td;
  logic [1:0]                     rsp_id;
`ifdef T_CALC_ARB_STATS_EN
  logic [N-1:0][31:0]             grant_cnt;
  logic [31:0]                    stall_cnt;
`endif

  t_calc_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_tx(req_tx), .req_ty(req_ty), .req_tz(req_tz),
    .mul_start(mul_start), .mul_dir(mul_dir),
    .mul_tx(mul_tx), .mul_ty(mul_ty), .mul_tz(mul_tz),
    .mul_valid(mul_valid), .mul_td(mul_td),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_td(rsp_td), .rsp_id(rsp_id)
`ifdef T_CALC_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Behavioural single-cycle t_calc: Q16 multiply per axis, tag passes through.
  function automatic TaggedDirection tcalc(input TaggedDirection d,
      input logic signed [31:0] a, input logic signed [31:0] b, input logic signed [31:0] c);
    TaggedDirection r;
    longint px, py, pz;
    px = longint'(d.x) * longint'(a);
    py = longint'(d.y) * longint'(b);
    pz = longint'(d.z) * longint'(c);
    r.x = 32'(px >>> 16);
    r.y = 32'(py >>> 16);
    r.z = 32'(pz >>> 16);
    r.tag = d.tag;
    return r;
  endfunction

  always @(posedge clk) begin
    mul_valid <= mul_start;
    if (mul_start) mul_td <= tcalc(mul_dir, mul_tx, mul_ty, mul_tz);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Advance one cycle and drive new inputs 1 ns after the edge.
  task automatic step(input logic [N-1:0] v, input logic rr);
    @(posedge clk);
    #1;
    req_valid = v;
    rsp_ready = rr;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       rr;
    logic [3:0] ready;
    logic       rv;
    logic [1:0] id;
  } vec_t;
  vec_t tbl [25];

  initial begin
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_dir[i].x   = 32'h0001_0000 * (i + 1);
      req_dir[i].y   = 32'h0001_0000;
      req_dir[i].z   = 32'h0001_0000;
      req_dir[i].tag = 48'(i);
      req_tx[i] = 32'h0001_0000;
      req_ty[i] = 32'h0001_0000;
      req_tz[i] = 32'h0001_0000;
    end

    // Grant order / credit / pointer scenarios: one row per cycle.
    tbl[0]  = '{4'hF, 1'b1, 4'h1, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'h2, 1'b0, 2'd0};
    tbl[2]  = '{4'hF, 1'b1, 4'h4, 1'b1, 2'd0};
    tbl[3]  = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd1};
    tbl[4]  = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd2};
    tbl[5]  = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3};
    tbl[6]  = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0};
    tbl[7]  = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0};
    tbl[8]  = '{4'hF, 1'b0, 4'h2, 1'b0, 2'd0};
    tbl[9]  = '{4'hF, 1'b0, 4'h4, 1'b0, 2'd0};
    tbl[10] = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
    tbl[11] = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
    tbl[12] = '{4'hF, 1'b0, 4'h0, 1'b1, 2'd1};
    tbl[13] = '{4'hF, 1'b1, 4'h8, 1'b1, 2'd1};
    tbl[14] = '{4'hF, 1'b1, 4'h1, 1'b1, 2'd2};
    tbl[15] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3};
    tbl[16] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd0};
    tbl[17] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0};
    tbl[18] = '{4'h2, 1'b1, 4'h2, 1'b0, 2'd0};
    tbl[19] = '{4'hA, 1'b1, 4'h8, 1'b0, 2'd0};
    tbl[20] = '{4'hA, 1'b1, 4'h2, 1'b1, 2'd1};
    tbl[21] = '{4'hA, 1'b1, 4'h8, 1'b1, 2'd3};
    tbl[22] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd1};
    tbl[23] = '{4'h0, 1'b1, 4'h0, 1'b1, 2'd3};
    tbl[24] = '{4'h0, 1'b1, 4'h0, 1'b0, 2'd0};

    // Reset state
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step('0, 1'b1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_mul_start", mul_start, 0);

    // Single job from requester 2: 2.0*1.5, 1.0*2.0, -1.0*1.0
    req_dir[2].x = 32'h0002_0000; req_tx[2] = 32'h0001_8000;
    req_dir[2].y = 32'h0001_0000; req_ty[2] = 32'h0002_0000;
    req_dir[2].z = 32'hFFFF_0000; req_tz[2] = 32'h0001_0000;
    req_dir[2].tag = 48'hABC;
    step(4'b0100, 1'b1);
    chk("s1_ready", req_ready, 4'b0100);
    chk("s1_start", mul_start, 1);
    chk("s1_mul_x", {mul_dir.x}, 32'h0002_0000);
    chk("s1_mul_tx", {mul_tx}, 32'h0001_8000);
    step('0, 1'b1);
    chk("s1_n1_rsp_valid", rsp_valid, 0);
    step('0, 1'b1);
    chk("s1_n2_rsp_valid", rsp_valid, 1);
    chk("s1_x", {rsp_td.x}, 32'h0003_0000);
    chk("s1_y", {rsp_td.y}, 32'h0002_0000);
    chk("s1_z", {rsp_td.z}, 32'hFFFF_0000);
    chk("s1_tag", rsp_td.tag, 48'hABC);
    chk("s1_id", rsp_id, 2);
    step('0, 1'b1);
    chk("s1_n3_rsp_valid", rsp_valid, 0);

    // Reset one cycle after an issue drops the result and rr_ptr.
    req_dir[0].tag = 48'h555;
    step(4'b0001, 1'b1);
    chk("s5_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1 req_valid = '0; rst_n = 1'b0;
    #1 chk("s5_in_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step('0, 1'b1);
      chk($sformatf("s5_dropped_%0d", c), rsp_valid, 0);
    end
    req_dir[1].tag = 48'h777;
    step(4'b1010, 1'b1);
    chk("s5_ptr_after_rst", req_ready, 4'b0010);
    step('0, 1'b1);
    chk("s5_n1_rsp_valid", rsp_valid, 0);
    step('0, 1'b1);
    chk("s5_n2_rsp_valid", rsp_valid, 1);
    chk("s5_id", rsp_id, 1);
    chk("s5_tag", rsp_td.tag, 48'h777);
    step('0, 1'b1);
    chk("s5_n3_rsp_valid", rsp_valid, 0);

    // Table-driven scenarios from a fresh reset.
    for (int i = 0; i < N; i++) req_dir[i].tag = 48'(i);
    do_reset();
`ifdef T_CALC_ARB_STATS_EN
    #1;
    chk("stats_rst_stall", stall_cnt, 0);
    chk("stats_rst_grant0", grant_cnt[0], 0);
`endif
    for (int r = 0; r < 25; r++) begin
      step(tbl[r].valid, tbl[r].rr);
      chk($sformatf("r%0d_ready", r), req_ready, tbl[r].ready);
      chk($sformatf("r%0d_start", r), mul_start, |tbl[r].ready);
      chk($sformatf("r%0d_rsp_valid", r), rsp_valid, tbl[r].rv);
      for (int g = 0; g < N; g++)
        if (tbl[r].ready[g]) chk($sformatf("r%0d_mul_tag", r), mul_dir.tag, 48'(g));
      if (tbl[r].rv) begin
        chk($sformatf("r%0d_rsp_id", r), rsp_id, tbl[r].id);
        chk($sformatf("r%0d_rsp_tag", r), rsp_td.tag, 48'(tbl[r].id));
      end
    end
    step('0, 1'b1);
`ifdef T_CALC_ARB_STATS_EN
    chk("stats_stall", stall_cnt, 3);
    chk("stats_grant0", grant_cnt[0], 3);
    chk("stats_grant1", grant_cnt[1], 4);
    chk("stats_grant2", grant_cnt[2], 2);
    chk("stats_grant3", grant_cnt[3], 4);
`endif
    chk("final_rsp_valid", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
